// File: rtl/mips_multicycle_control.sv
`timescale 1ns/1ps
// mips_multicycle_control
//
// Multicycle control sequencer for a 32-bit MIPS datapath. Steps one
// instruction at a time through fetch, decode, execute, memory and
// writeback, and drives the ALU operation and the datapath selects and enables.
//
// Ports
//   clk          : system clock, rising edge
//   reset_n      : asynchronous active-low reset
//   opcode       : IR[31:26], held stable from DECODE until the instruction completes
//   funct        : IR[5:0], same stability as opcode
//   zero         : ALU zero flag, used combinationally in BRANCH
//   alu_control  : 0010 add, 0110 sub, 0111 slt, 0000 when the ALU is unused
//   alu_src_a    : 0 = PC, 1 = register A
//   alu_src_b    : 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
//   pc_write     : PC load enable
//   pc_source    : 00 = ALU result, 01 = ALUOut, 10 = jump target
//   ir_write     : IR load enable
//   mem_read     : memory read strobe
//   mem_write    : memory write strobe
//   i_or_d       : memory address select, 0 = PC, 1 = ALUOut
//   reg_write    : register file write enable
//   reg_dst      : 0 = rt, 1 = rd
//   mem_to_reg   : 0 = ALUOut, 1 = MDR
//   retire       : one-cycle pulse in the last state of a legal instruction
//   illegal      : one-cycle pulse in DECODE for an unsupported instruction
//   state        : current state code, for debug
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | after reset; no datapath activity
// FETCH     | read instruction, load IR, PC <= PC + 4
// DECODE    | branch target into ALUOut, dispatch on opcode/funct
// MEM_ADDR  | effective address A + imm for lw/sw
// MEM_READ  | read data memory at ALUOut
// MEM_WB    | write MDR into rt (lw retires)
// MEM_WRITE | write B to memory at ALUOut (sw retires)
// EXEC_R    | A op B, op taken from funct
// R_WB      | write ALUOut into rd (R-type retires)
// EXEC_I    | A + imm
// I_WB      | write ALUOut into rt (addi retires)
// BRANCH    | A - B; PC <= ALUOut when zero (beq retires)
// JUMP      | PC <= jump target (j retires)

module mips_multicycle_control (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [3:0] alu_control,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       pc_write,
    output logic [1:0] pc_source,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       retire,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXEC_R    = 4'd7,
        S_R_WB      = 4'd8,
        S_EXEC_I    = 4'd9,
        S_I_WB      = 4'd10,
        S_BRANCH    = 4'd11,
        S_JUMP      = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_NONE = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;

    function automatic logic [3:0] r_alu_op(input logic [5:0] f);
        case (f)
            FN_ADD:  return ALU_ADD;
            FN_SUB:  return ALU_SUB;
            FN_SLT:  return ALU_SLT;
            default: return ALU_NONE;
        endcase
    endfunction

    state_t cur_state;
    state_t nxt_state;
    logic   r_legal;
    logic   pc_write_q;

    assign r_legal = (opcode == OP_RTYPE) &&
                     ((funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_SLT));

    always_comb begin
        nxt_state = S_IDLE;
        case (cur_state)
            S_IDLE:   nxt_state = S_FETCH;
            S_FETCH:  nxt_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: nxt_state = S_MEM_ADDR;
                    OP_RTYPE:     nxt_state = r_legal ? S_EXEC_R : S_FETCH;
                    OP_ADDI:      nxt_state = S_EXEC_I;
                    OP_BEQ:       nxt_state = S_BRANCH;
                    OP_J:         nxt_state = S_JUMP;
                    default:      nxt_state = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  nxt_state = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  nxt_state = S_MEM_WB;
            S_MEM_WB:    nxt_state = S_FETCH;
            S_MEM_WRITE: nxt_state = S_FETCH;
            S_EXEC_R:    nxt_state = S_R_WB;
            S_R_WB:      nxt_state = S_FETCH;
            S_EXEC_I:    nxt_state = S_I_WB;
            S_I_WB:      nxt_state = S_FETCH;
            S_BRANCH:    nxt_state = S_FETCH;
            S_JUMP:      nxt_state = S_FETCH;
            default:     nxt_state = S_IDLE;
        endcase
    end

    // Outputs are registered from the state being entered, so they line up
    // with that state. funct is already stable when DECODE exits, which lets
    // the EXEC_R ALU op be registered too.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_state   <= S_IDLE;
            alu_control <= ALU_NONE;
            alu_src_a   <= 1'b0;
            alu_src_b   <= 2'b00;
            pc_write_q  <= 1'b0;
            pc_source   <= 2'b00;
            ir_write    <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            i_or_d      <= 1'b0;
            reg_write   <= 1'b0;
            reg_dst     <= 1'b0;
            mem_to_reg  <= 1'b0;
            retire      <= 1'b0;
        end else begin
            cur_state   <= nxt_state;
            alu_control <= ALU_NONE;
            alu_src_a   <= 1'b0;
            alu_src_b   <= 2'b00;
            pc_write_q  <= 1'b0;
            pc_source   <= 2'b00;
            ir_write    <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            i_or_d      <= 1'b0;
            reg_write   <= 1'b0;
            reg_dst     <= 1'b0;
            mem_to_reg  <= 1'b0;
            retire      <= 1'b0;
            case (nxt_state)
                S_FETCH: begin
                    mem_read    <= 1'b1;
                    ir_write    <= 1'b1;
                    alu_src_b   <= 2'b01;
                    alu_control <= ALU_ADD;
                    pc_write_q  <= 1'b1;
                end
                S_DECODE: begin
                    alu_src_b   <= 2'b11;
                    alu_control <= ALU_ADD;
                end
                S_MEM_ADDR, S_EXEC_I: begin
                    alu_src_a   <= 1'b1;
                    alu_src_b   <= 2'b10;
                    alu_control <= ALU_ADD;
                end
                S_MEM_READ: begin
                    mem_read <= 1'b1;
                    i_or_d   <= 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  <= 1'b1;
                    mem_to_reg <= 1'b1;
                    retire     <= 1'b1;
                end
                S_MEM_WRITE: begin
                    mem_write <= 1'b1;
                    i_or_d    <= 1'b1;
                    retire    <= 1'b1;
                end
                S_EXEC_R: begin
                    alu_src_a   <= 1'b1;
                    alu_control <= r_alu_op(funct);
                end
                S_R_WB: begin
                    reg_write <= 1'b1;
                    reg_dst   <= 1'b1;
                    retire    <= 1'b1;
                end
                S_I_WB: begin
                    reg_write <= 1'b1;
                    retire    <= 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a   <= 1'b1;
                    alu_control <= ALU_SUB;
                    pc_source   <= 2'b01;
                    retire      <= 1'b1;
                end
                S_JUMP: begin
                    pc_source  <= 2'b10;
                    pc_write_q <= 1'b1;
                    retire     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // zero only settles during BRANCH itself, so the branch PC enable is
    // combinational. IR is loaded at the FETCH->DECODE edge, so legality can
    // only be judged combinationally inside DECODE.
    assign pc_write = pc_write_q | ((cur_state == S_BRANCH) & zero);
    assign illegal  = (cur_state == S_DECODE) &&
                      !((opcode == OP_LW) || (opcode == OP_SW) || r_legal ||
                        (opcode == OP_ADDI) || (opcode == OP_BEQ) || (opcode == OP_J));
    assign state    = cur_state;

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multicycle control sequencer that drives the 32-bit MIPS ALU and the surrounding datapath. It issues the 4-bit ALU operation code, operand selects and datapath enables each cycle. It consumes the ALU `zero` flag to resolve `beq`. It sits between the instruction register (opcode/funct fields) and the multicycle datapath, and steps one instruction through fetch, decode, execute, memory and writeback states.

## Interface
Parameters: none.

Ports:
- `clk` input 1 — sole clock; all state updates on rising edge.
- `reset_n` input 1 — asynchronous, active-low reset.
- `opcode` input 6 — IR[31:26]; must be stable from the DECODE cycle until the instruction completes.
- `funct` input 6 — IR[5:0]; same stability requirement as `opcode`.
- `zero` input 1 — ALU zero flag, sampled combinationally in BRANCH.
- `alu_control` output 4 — 0010 add, 0110 sub, 0111 slt; 0000 when no ALU use is needed.
- `alu_src_a` output 1 — 0 = PC, 1 = register A.
- `alu_src_b` output 2 — 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `pc_write` output 1 — PC load enable.
- `pc_source` output 2 — 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `ir_write` output 1 — IR load enable.
- `mem_read`, `mem_write` output 1 each — memory strobes.
- `i_or_d` output 1 — memory address select: 0 = PC, 1 = ALUOut.
- `reg_write` output 1 — register file write enable.
- `reg_dst` output 1 — 0 = rt, 1 = rd.
- `mem_to_reg` output 1 — 0 = ALUOut, 1 = MDR.
- `retire` output 1 — one-cycle pulse in the final state of each legal instruction.
- `illegal` output 1 — one-cycle pulse in DECODE for an unsupported opcode/funct.
- `state` output 4 — current state code, for debug.

## Operation
- Moore FSM with a 4-bit registered state. Every output is decoded from the state; the only exceptions are `alu_control` in EXEC_R (decoded from `funct`), `pc_write` in BRANCH (equal to `zero`), and `illegal` in DECODE.
- Any output not listed for a state is 0.
- State encoding: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXEC_R=7, R_WB=8, EXEC_I=9, I_WB=10, BRANCH=11, JUMP=12. Codes 13–15 go to IDLE on the next edge.
- **IDLE:** all outputs 0. Next state FETCH.
- **FETCH:** mem_read=1, ir_write=1, alu_src_b=01, alu_control=0010, pc_write=1. Next state DECODE.
- **DECODE:** alu_src_b=11, alu_control=0010 (branch target into ALUOut). Next state by opcode:
  - 100011 (lw) or 101011 (sw) → MEM_ADDR.
  - 000000 with funct 100000/100010/101010 → EXEC_R.
  - 001000 (addi) → EXEC_I.
  - 000100 (beq) → BRANCH.
  - 000010 (j) → JUMP.
  - Anything else: illegal=1 → FETCH.
- **MEM_ADDR:** alu_src_a=1, alu_src_b=10, alu_control=0010. Next state MEM_READ for lw, MEM_WRITE for sw.
- **MEM_READ:** mem_read=1, i_or_d=1 → MEM_WB.
- **MEM_WB:** reg_write=1, mem_to_reg=1, retire=1 → FETCH.
- **MEM_WRITE:** mem_write=1, i_or_d=1, retire=1 → FETCH.
- **EXEC_R:** alu_src_a=1, alu_src_b=00, alu_control from funct (100000→0010, 100010→0110, 101010→0111) → R_WB.
- **R_WB:** reg_write=1, reg_dst=1, retire=1 → FETCH.
- **EXEC_I:** alu_src_a=1, alu_src_b=10, alu_control=0010 → I_WB.
- **I_WB:** reg_write=1, retire=1 → FETCH.
- **BRANCH:** alu_src_a=1, alu_src_b=00, alu_control=0110, pc_source=01, pc_write=zero, retire=1 → FETCH.
- **JUMP:** pc_source=10, pc_write=1, retire=1 → FETCH.

## Timing
- Reset: asserting `reset_n` low forces state=IDLE immediately (asynchronously). All outputs read 0 while reset is held, including `state`=0.
- After reset is released, the first edge moves to FETCH, so the first fetch occurs in the second cycle.
- Reset mid-instruction abandons the instruction. No retire is issued and no write strobes are produced after reset asserts.
- Latency in cycles, FETCH through the retire cycle: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. An illegal instruction takes 2 cycles and is not retired.
- `pc_write` in BRANCH follows `zero` within the same cycle. The ALU result must settle before the clock edge; there is no registered flag.
- Back-to-back instructions: the edge out of every retire state or the illegal DECODE goes to FETCH with no bubble.

## Test plan
- Reset: hold reset_n=0 for 3 cycles with opcode=100011 → state=0 and every output 0. Release → FETCH next cycle with mem_read=1, ir_write=1, pc_write=1, alu_src_b=01, alu_control=0010.
- lw (opcode 100011) → state sequence 1,2,3,4,5. retire=1 only in state 5, alongside reg_write=1, mem_to_reg=1, reg_dst=0.
- R-type with opcode 0 and funct 101010 → EXEC_R shows alu_control=0111, alu_src_a=1, alu_src_b=00. R_WB shows reg_write=1, reg_dst=1. Repeat with 100010 → 0110 and with 100000 → 0010.
- beq with zero=1 → BRANCH shows pc_write=1, pc_source=01, alu_control=0110. With zero=0 → pc_write=0; retire=1 in both cases.
- Illegal opcode 111111, and opcode 0 with funct 000000 → illegal=1 in DECODE, next state FETCH, no reg_write or mem_write pulse, retire never asserted.
- Reset mid-operation: assert reset_n=0 in MEM_READ of an lw → state=0 immediately, no MEM_WB reg_write. After release, a fresh fetch follows.
